// File: rtl/debounce_botoes_if.sv
// rtl/debounce_botoes_if.sv - button conditioning bundle: raw levels and enable in, debounced levels and press pulses out
//
// botoes_raw      raw, asynchronous, bouncing button levels
// on_off          enable; 0 suppresses pulse generation
// pulsos          registered one-cycle press pulses, one-hot or zero
// estavel         registered debounced level, 1 = pressed
// pulso_qualquer  registered OR of pulsos
interface debounce_botoes_if #(
    parameter int N_BOTOES = 4
);
    logic [N_BOTOES-1:0] botoes_raw;
    logic                on_off;
    logic [N_BOTOES-1:0] pulsos;
    logic [N_BOTOES-1:0] estavel;
    logic                pulso_qualquer;

    modport master (
        output botoes_raw,
        output on_off,
        input  pulsos,
        input  estavel,
        input  pulso_qualquer
    );

    modport slave (
        input  botoes_raw,
        input  on_off,
        output pulsos,
        output estavel,
        output pulso_qualquer
    );
endinterface

// File: rtl/debounce_botoes.sv
// rtl/debounce_botoes.sv - 2-FF sync, per-button debounce FSM and one-hot press pulse for the password stage
//
// clk    system clock
// reset  asynchronous, active-high reset
// bus    debounce_botoes_if.slave: botoes_raw/on_off in, pulsos/estavel/pulso_qualquer out
module debounce_botoes #(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    debounce_botoes_if.slave  bus
);
    localparam int                  CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    // Raw level of a released button; the sync chain resets to it so no
    // spurious press is seen coming out of reset.
    localparam logic [N_BOTOES-1:0] RAW_SOLTO = {N_BOTOES{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        SOLTO,
        CONF_PRESS,
        PRESSIONADO,
        CONF_SOLTO
    } estado_t;

    logic [N_BOTOES-1:0] sync1_q;
    logic [N_BOTOES-1:0] sync2_q;
    logic [N_BOTOES-1:0] p;

    estado_t             estado_q  [N_BOTOES];
    estado_t             estado_d  [N_BOTOES];
    logic [CNT_W-1:0]    cnt_q     [N_BOTOES];
    logic [CNT_W-1:0]    cnt_d     [N_BOTOES];

    logic [N_BOTOES-1:0] req;
    logic [N_BOTOES-1:0] grant;
    logic [N_BOTOES-1:0] estavel_d;

    logic [N_BOTOES-1:0] pulsos_q;
    logic [N_BOTOES-1:0] estavel_q;
    logic                pulso_qualquer_q;

    // 1 = pressed, independent of board polarity
    assign p = sync2_q ^ RAW_SOLTO;

    always_comb begin
        req       = '0;
        estavel_d = '0;
        for (int i = 0; i < N_BOTOES; i++) begin
            estado_d[i] = estado_q[i];
            cnt_d[i]    = cnt_q[i];
            case (estado_q[i])
                SOLTO: begin
                    if (p[i]) begin
                        estado_d[i] = CONF_PRESS;
                        cnt_d[i]    = CNT_ONE;
                    end else begin
                        cnt_d[i]    = '0;
                    end
                end
                CONF_PRESS: begin
                    if (!p[i]) begin
                        // a bounce restarts the confirmation from scratch
                        estado_d[i] = SOLTO;
                        cnt_d[i]    = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        estado_d[i] = PRESSIONADO;
                        cnt_d[i]    = '0;
                        req[i]      = 1'b1;
                    end else begin
                        cnt_d[i]    = cnt_q[i] + CNT_ONE;
                    end
                end
                PRESSIONADO: begin
                    if (!p[i]) begin
                        estado_d[i] = CONF_SOLTO;
                        cnt_d[i]    = CNT_ONE;
                    end else begin
                        cnt_d[i]    = '0;
                    end
                end
                CONF_SOLTO: begin
                    if (p[i]) begin
                        estado_d[i] = PRESSIONADO;
                        cnt_d[i]    = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        estado_d[i] = SOLTO;
                        cnt_d[i]    = '0;
                    end else begin
                        cnt_d[i]    = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    estado_d[i] = SOLTO;
                    cnt_d[i]    = '0;
                end
            endcase
            estavel_d[i] = (estado_d[i] == PRESSIONADO) || (estado_d[i] == CONF_SOLTO);
        end
    end

    // Isolate the lowest set request; losers are dropped, never queued.
    assign grant = req & (~req + N_BOTOES'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q          <= RAW_SOLTO;
            sync2_q          <= RAW_SOLTO;
            pulsos_q         <= '0;
            estavel_q        <= '0;
            pulso_qualquer_q <= 1'b0;
            for (int i = 0; i < N_BOTOES; i++) begin
                estado_q[i] <= SOLTO;
                cnt_q[i]    <= '0;
            end
        end else begin
            sync1_q          <= bus.botoes_raw;
            sync2_q          <= sync1_q;
            pulsos_q         <= bus.on_off ? grant : '0;
            estavel_q        <= estavel_d;
            pulso_qualquer_q <= bus.on_off & (|req);
            for (int i = 0; i < N_BOTOES; i++) begin
                estado_q[i] <= estado_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    assign bus.pulsos         = pulsos_q;
    assign bus.estavel        = estavel_q;
    assign bus.pulso_qualquer = pulso_qualquer_q;
endmodule

// File: tb/tb_debounce_botoes.sv
// tb/tb_debounce_botoes.sv - self-checking bench for debounce_botoes with run-length reference model
module tb_debounce_botoes;
    localparam int DC = 4;

    logic clk;
    logic reset;

    debounce_botoes_if #(.N_BOTOES(4)) bif ();

    debounce_botoes #(
        .N_BOTOES(4),
        .DEBOUNCE_CYCLES(DC),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pcnt [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pressed level is accepted after DC consecutive
    // samples that disagree with the currently accepted level; the raw input
    // reaches the sampler two edges late.
    logic [3:0] m_s1, m_s2, m_p, m_rise;
    logic [3:0] m_pulsos, m_estavel;
    logic       m_pq;
    bit         m_lvl [4];
    int         m_run [4];
    int         m_win;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1     = 4'hF;
            m_s2     = 4'hF;
            m_pulsos = '0;
            m_estavel = '0;
            m_pq     = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_lvl[i] = 1'b0;
                m_run[i] = 0;
            end
        end else begin
            m_p    = ~m_s2;
            m_rise = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_p[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_lvl[i] = !m_lvl[i];
                        m_run[i] = 0;
                        if (m_lvl[i]) m_rise[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_estavel[i] = m_lvl[i];
            end
            m_win = -1;
            for (int i = 3; i >= 0; i--) if (m_rise[i]) m_win = i;
            m_pulsos = (bif.on_off && m_win >= 0) ? 4'(1 << m_win) : 4'b0000;
            m_pq     = |m_pulsos;
            m_s2     = m_s1;
            m_s1     = bif.botoes_raw;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("cmp_pulsos", int'(bif.pulsos), int'(m_pulsos));
            check("cmp_estavel", int'(bif.estavel), int'(m_estavel));
            check("cmp_pulso_qualquer", int'(bif.pulso_qualquer), int'(m_pq));
            for (int i = 0; i < 4; i++) if (bif.pulsos[i]) pcnt[i]++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 4; i++) pcnt[i] = 0;
    endtask

    task automatic first_pulse(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bif.pulsos != 4'b0000) begin
                lat = n;
                break;
            end
        end
    endtask

    int lat;

    initial begin
        reset          = 1'b1;
        bif.botoes_raw = 4'hF;
        bif.on_off     = 1'b1;
        clr();
        step(3);
        check("reset_pulsos", int'(bif.pulsos), 0);
        check("reset_estavel", int'(bif.estavel), 0);
        check("reset_pq", int'(bif.pulso_qualquer), 0);
        reset = 1'b0;
        step(5);

        // clean press on channel 2
        clr();
        bif.botoes_raw[2] = 1'b0;
        first_pulse(lat);
        check("clean_latency", lat, 6);
        check("clean_pulsos", int'(bif.pulsos), 4);
        check("clean_pq", int'(bif.pulso_qualquer), 1);
        check("clean_estavel2", int'(bif.estavel[2]), 1);
        step(19);
        check("clean_one_pulse", pcnt[2], 1);
        check("model_estavel_pin", int'(m_estavel), 4);
        bif.botoes_raw[2] = 1'b1;
        step(10);
        check("clean_released", int'(bif.estavel), 0);

        // bounce on channel 0, then a genuine press
        clr();
        bif.botoes_raw[0] = 1'b0; step(2);
        bif.botoes_raw[0] = 1'b1; step(1);
        bif.botoes_raw[0] = 1'b0; step(2);
        bif.botoes_raw[0] = 1'b1; step(8);
        check("bounce_no_pulse", pcnt[0], 0);
        check("bounce_estavel0", int'(bif.estavel[0]), 0);
        bif.botoes_raw[0] = 1'b0; step(6);
        bif.botoes_raw[0] = 1'b1; step(10);
        check("bounce_then_press", pcnt[0], 1);

        // simultaneous press on channels 1 and 3
        clr();
        bif.botoes_raw[1] = 1'b0;
        bif.botoes_raw[3] = 1'b0;
        step(10);
        check("simul_pulse1", pcnt[1], 1);
        check("simul_pulse3", pcnt[3], 0);
        check("simul_estavel", int'(bif.estavel), 10);
        bif.botoes_raw = 4'hF;
        step(10);

        // enable gating
        clr();
        bif.on_off = 1'b0;
        bif.botoes_raw[1] = 1'b0; step(10);
        check("gate_off_no_pulse", pcnt[1], 0);
        check("gate_off_estavel", int'(bif.estavel[1]), 1);
        bif.on_off = 1'b1; step(10);
        check("gate_on_held_no_pulse", pcnt[1], 0);
        bif.botoes_raw[1] = 1'b1; step(8);
        bif.botoes_raw[1] = 1'b0; step(10);
        check("gate_repress_pulse", pcnt[1], 1);
        bif.botoes_raw[1] = 1'b1; step(10);

        // long hold and bouncy release on channel 3
        clr();
        bif.botoes_raw[3] = 1'b0; step(100);
        check("hold_one_pulse", pcnt[3], 1);
        bif.botoes_raw[3] = 1'b1; step(1);
        bif.botoes_raw[3] = 1'b0; step(1);
        bif.botoes_raw[3] = 1'b1;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (!bif.estavel[3]) begin
                lat = n;
                break;
            end
        end
        check("release_latency", lat, 6);
        step(5);
        check("release_no_pulse", pcnt[3], 1);

        // randomized traffic, checked every cycle by the model
        for (int k = 0; k < 300; k++) begin
            bif.botoes_raw = 4'($urandom);
            if ($urandom_range(0, 9) == 0) bif.on_off = ~bif.on_off;
            step($urandom_range(1, 8));
        end
        bif.botoes_raw = 4'hF;
        bif.on_off     = 1'b1;
        step(10);

        // async reset in the middle of a confirmation
        bif.botoes_raw[2] = 1'b0; step(10);
        bif.botoes_raw[0] = 1'b0; step(4);
        check("pre_reset_estavel", int'(bif.estavel), 4);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_estavel", int'(bif.estavel), 0);
        check("async_reset_pulsos", int'(bif.pulsos), 0);
        check("async_reset_pq", int'(bif.pulso_qualquer), 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        clr();
        first_pulse(lat);
        check("post_reset_latency", lat, 6);
        check("post_reset_pulsos", int'(bif.pulsos), 1);
        step(10);
        check("post_reset_single", pcnt[0] + pcnt[2], 1);
        check("post_reset_estavel", int'(bif.estavel), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
